// File: rtl/soc_design_fb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : soc_design_fb_pkg
// Brief    : Shared register addresses and edge-type encodings for the
//            framebuffer status input port.
// Revision : 1.0 - initial release
// ============================================================================
package soc_design_fb_pkg;

    localparam logic [1:0] FB_ADDR_DATA    = 2'd0;
    localparam logic [1:0] FB_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] FB_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] FB_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/soc_design_fb_sync_edge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : soc_design_fb_sync_edge
// Brief    : Vectorised synchroniser chain, delay flop and edge selector.
// Revision : 1.0 - initial release
// ============================================================================
module soc_design_fb_sync_edge
    import soc_design_fb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] sync_out,
    output logic [DATA_WIDTH-1:0] edge_out
);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_d;
    logic [DATA_WIDTH-1:0]                  dly_q;
    logic [DATA_WIDTH-1:0]                  dly_d;
    logic [DATA_WIDTH-1:0]                  w_sync;

    assign w_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
        dly_d  = w_sync;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
            assign edge_out = ~w_sync & dly_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
            assign edge_out = w_sync ^ dly_q;
        end else begin : g_edge_rise
            assign edge_out = w_sync & ~dly_q;
        end
    endgenerate

    assign sync_out = w_sync;

endmodule
`default_nettype wire

// File: rtl/soc_design_fb_status_in.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : soc_design_fb_status_in
// Brief    : Avalon-MM slave returning framebuffer status lines to the HPS,
//            with sticky edge capture and a maskable level interrupt.
//            Optional macro FB_STATUS_IRQ_EN enables IRQMASK and irq.
// Revision : 1.0 - initial release
// ============================================================================
module soc_design_fb_status_in
    import soc_design_fb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    localparam int                 c_prime_cycles = SYNC_STAGES + 1;
    localparam int                 c_prime_w      = $clog2(c_prime_cycles + 1);
    localparam logic [c_prime_w-1:0] c_prime_done = c_prime_w'(c_prime_cycles);

    logic [DATA_WIDTH-1:0] w_sync;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_irqmask;
    logic [31:0]           w_rd_mux;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_prime_done;

    logic [c_prime_w-1:0]  prime_q,    prime_d;
    logic [DATA_WIDTH-1:0] edgecap_q,  edgecap_d;
    logic [31:0]           readdata_q, readdata_d;

    soc_design_fb_sync_edge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .sync_out (w_sync),
        .edge_out (w_edge)
    );

    assign w_wr_en      = chipselect & ~write_n;
    assign w_rd_en      = chipselect & read;
    assign w_prime_done = (prime_q == c_prime_done);

    always_comb begin
        w_rd_mux = '0;
        case (address)
            FB_ADDR_DATA:    w_rd_mux[DATA_WIDTH-1:0] = w_sync;
            FB_ADDR_IRQMASK: w_rd_mux[DATA_WIDTH-1:0] = w_irqmask;
            FB_ADDR_EDGECAP: w_rd_mux[DATA_WIDTH-1:0] = edgecap_q;
            default:         w_rd_mux = '0;
        endcase
    end

    // Clear is applied first so a same-cycle edge still sets the bit.
    always_comb begin
        readdata_d = w_rd_en ? w_rd_mux : readdata_q;
        prime_d    = w_prime_done ? prime_q : prime_q + c_prime_w'(1);
        edgecap_d  = edgecap_q;
        if (w_wr_en && (address == FB_ADDR_EDGECAP)) begin
            edgecap_d = edgecap_q & ~writedata[DATA_WIDTH-1:0];
        end
        if (w_prime_done) begin
            edgecap_d = edgecap_d | w_edge;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_q    <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            prime_q    <= prime_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

`ifdef FB_STATUS_IRQ_EN
    logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
    logic                  irq_q,     irq_d;

    always_comb begin
        irqmask_d = irqmask_q;
        if (w_wr_en && (address == FB_ADDR_IRQMASK)) begin
            irqmask_d = writedata[DATA_WIDTH-1:0];
        end
        irq_d = |(edgecap_q & irqmask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            irqmask_q <= irqmask_d;
            irq_q     <= irq_d;
        end
    end

    assign w_irqmask = irqmask_q;
    assign irq       = irq_q;
`else
    assign w_irqmask = '0;
    assign irq       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_soc_design_fb_status_in.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_soc_design_fb_status_in
// Brief    : Self-checking bench: vector table, multi-cycle corner sequences
//            and a randomized run against a history-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_design_fb_status_in;

    localparam int S  = 2;
`ifdef FB_STATUS_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, read, write_n;
    logic [31:0] writedata, readdata, in_port;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    soc_design_fb_status_in #(
        .DATA_WIDTH (32),
        .SYNC_STAGES(S),
        .EDGE_TYPE  (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: in_port history indexed by cycles since reset release.
    logic [31:0] hist[$];
    int          m_cnt;
    logic [31:0] m_rd, m_cap, m_mask, m_s, m_d, m_e, m_val;
    logic        m_irq, m_irq_n;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist = {};
            for (int i = 0; i < S + 2; i++) hist.push_back(32'h0);
            m_cnt  = 0;
            m_rd   = 32'h0;
            m_cap  = 32'h0;
            m_mask = 32'h0;
            m_irq  = 1'b0;
        end else begin
            m_cnt++;
            hist.push_front(in_port);
            void'(hist.pop_back());
            m_s = hist[S];
            m_d = hist[S + 1];
            case (address)
                2'd0:    m_val = m_s;
                2'd2:    m_val = m_mask;
                2'd3:    m_val = m_cap;
                default: m_val = 32'h0;
            endcase
            m_irq_n = IRQ_EN && ((m_cap & m_mask) != 32'h0);
            if (chipselect && read) m_rd = m_val;
            m_e = m_s & ~m_d;
            if (m_cnt < S + 2) m_e = 32'h0;
            if (chipselect && !write_n && address == 2'd3) m_cap = m_cap & ~writedata;
            m_cap = m_cap | m_e;
            if (IRQ_EN && chipselect && !write_n && address == 2'd2) m_mask = writedata;
            m_irq = m_irq_n;
        end
    end

    typedef struct {
        logic [31:0] inp;
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic [31:0] inp, bit wr, logic [1:0] a,
                                logic [31:0] wd, logic [31:0] er, bit ei);
        vec_t v;
        v.inp = inp; v.wr = wr; v.addr = a; v.wd = wd; v.exp_rd = er; v.exp_irq = ei;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_op(input bit wr, input logic [1:0] a, input logic [31:0] wd);
        chipselect = 1'b1;
        read       = !wr;
        write_n    = !wr;
        address    = a;
        writedata  = wd;
        @(negedge clk);
        bus_idle();
    endtask

    initial begin
        logic [31:0] m1, m2;
        m1 = {31'b0, IRQ_EN};
        m2 = IRQ_EN ? 32'h2 : 32'h0;
        tbl[0]  = mk(32'hFFFF_FFFF, 0, 2'd3, 32'h0,    32'h0,         1'b0);
        tbl[1]  = mk(32'hFFFF_FFFF, 0, 2'd1, 32'h0,    32'h0,         1'b0);
        tbl[2]  = mk(32'hFFFF_FFFF, 0, 2'd0, 32'h0,    32'hFFFF_FFFF, 1'b0);
        tbl[3]  = mk(32'hFFFF_FFFF, 1, 2'd0, 32'h1234, 32'hFFFF_FFFF, 1'b0);
        tbl[4]  = mk(32'h0,         0, 2'd3, 32'h0,    32'h0,         1'b0);
        tbl[5]  = mk(32'h0,         1, 2'd2, 32'h1,    32'h0,         1'b0);
        tbl[6]  = mk(32'h1,         0, 2'd3, 32'h0,    32'h1,         IRQ_EN);
        tbl[7]  = mk(32'h1,         0, 2'd2, 32'h0,    m1,            IRQ_EN);
        tbl[8]  = mk(32'h5,         0, 2'd3, 32'h0,    32'h5,         IRQ_EN);
        tbl[9]  = mk(32'h5,         1, 2'd3, 32'h4,    32'h5,         IRQ_EN);
        tbl[10] = mk(32'h5,         0, 2'd3, 32'h0,    32'h1,         IRQ_EN);
        tbl[11] = mk(32'h5,         1, 2'd3, 32'h1,    32'h1,         1'b0);
        tbl[12] = mk(32'h7,         0, 2'd3, 32'h0,    32'h2,         1'b0);
        tbl[13] = mk(32'h7,         1, 2'd2, 32'h2,    32'h2,         IRQ_EN);
        tbl[14] = mk(32'h7,         0, 2'd2, 32'h0,    m2,            IRQ_EN);
        tbl[15] = mk(32'h7,         1, 2'd2, 32'h0,    m2,            1'b0);
        tbl[16] = mk(32'h6,         0, 2'd3, 32'h0,    32'h2,         1'b0);
        tbl[17] = mk(32'h6,         0, 2'd0, 32'h0,    32'h6,         1'b0);

        reset     = 1'b1;
        in_port   = 32'hFFFF_FFFF;
        address   = 2'd0;
        writedata = 32'h0;
        bus_idle();
        repeat (3) @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            in_port = tbl[i].inp;
            repeat (6) @(negedge clk);
            bus_op(tbl[i].wr, tbl[i].addr, tbl[i].wd);
            @(negedge clk);
            check($sformatf("vec%0d_readdata", i), readdata, tbl[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
        end

        // Capture and irq latency after a single rising edge.
        in_port = 32'h0;
        repeat (6) @(negedge clk);
        bus_op(1, 2'd3, 32'hFFFF_FFFF);
        bus_op(1, 2'd2, 32'h1);
        @(negedge clk);
        in_port    = 32'h1;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 2'd3;
        for (int k = 1; k <= S + 2; k++) begin
            @(negedge clk);
            if (k == S + 1) begin
                check("lat_cap_early", readdata, 32'h0);
                check("lat_irq_early", {31'b0, irq}, 32'h0);
            end
            if (k == S + 2) begin
                check("lat_cap", readdata, 32'h1);
                check("lat_irq", {31'b0, irq}, {31'b0, IRQ_EN});
            end
        end
        bus_idle();

        // Clear written on the very cycle the edge is captured: set wins.
        in_port = 32'h0;
        repeat (6) @(negedge clk);
        bus_op(1, 2'd3, 32'hFFFF_FFFF);
        @(negedge clk);
        bus_op(0, 2'd3, 32'h0);
        @(negedge clk);
        check("collide_pre", readdata, 32'h0);
        in_port = 32'h1;
        repeat (S) @(negedge clk);
        bus_op(1, 2'd3, 32'h1);
        @(negedge clk);
        bus_op(0, 2'd3, 32'h0);
        @(negedge clk);
        check("collide_set_wins", readdata, 32'h1);

        // One cycle later the clear lands after the set and removes it.
        in_port = 32'h0;
        repeat (6) @(negedge clk);
        bus_op(1, 2'd3, 32'hFFFF_FFFF);
        in_port = 32'h1;
        repeat (S + 1) @(negedge clk);
        bus_op(1, 2'd3, 32'h1);
        @(negedge clk);
        bus_op(0, 2'd3, 32'h0);
        @(negedge clk);
        check("late_clear", readdata, 32'h0);

        // Asynchronous reset with irq high and a read in flight.
        in_port = 32'h0;
        repeat (6) @(negedge clk);
        in_port = 32'h1;
        repeat (6) @(negedge clk);
        bus_op(0, 2'd0, 32'h0);
        @(negedge clk);
        check("midrst_pre_rd", readdata, 32'h1);
        check("midrst_pre_irq", {31'b0, irq}, {31'b0, IRQ_EN});
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 2'd3;
        #2 reset = 1'b1;
        #1;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        bus_idle();
        reset = 1'b0;
        repeat (6) @(negedge clk);
        bus_op(0, 2'd3, 32'h0);
        @(negedge clk);
        check("midrst_cap_after", readdata, 32'h0);
        bus_op(0, 2'd2, 32'h0);
        @(negedge clk);
        check("midrst_mask_after", readdata, 32'h0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            in_port    = in_port ^ ($urandom & $urandom & $urandom);
            chipselect = 1'($urandom_range(0, 1));
            read       = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            @(negedge clk);
            check("rnd_readdata", readdata, m_rd);
            check("rnd_irq", {31'b0, irq}, {31'b0, m_irq});
        end
        bus_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
